// File: rtl/dmem_pipe_if.sv
// Request/response bus between the Y86 memory stage (master) and dmem_pipe (slave).
interface dmem_pipe_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              req_mem;
  logic              ready_mem;
  logic [ADDR_W-1:0] address_mem;
  logic [DATA_W-1:0] valA_mem;
  logic              read_mem;
  logic              write_mem;
  logic [DATA_W-1:0] data_memory;
  logic              valid_mem;
  logic              error_mem;

  modport master (
    output req_mem, address_mem, valA_mem, read_mem, write_mem,
    input  ready_mem, data_memory, valid_mem, error_mem
  );

  modport slave (
    input  req_mem, address_mem, valA_mem, read_mem, write_mem,
    output ready_mem, data_memory, valid_mem, error_mem
  );
endinterface

// File: rtl/dmem_pipe.sv
// Clocked Y86 data memory: one request in flight, fixed read latency,
// alignment/bounds checking and read-as-zero for never-written words.
module dmem_pipe #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = 8192,
  parameter int LATENCY = 2
) (
  input logic         clk,
  input logic         rst_n,
  dmem_pipe_if.slave  bus
);
  localparam int SH    = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              err_q, err_d;
  logic [DEPTH-1:0]  written_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              ready;
  logic              accept;
  logic              legal;
  logic              misaligned;
  logic              out_of_range;
  logic              we;
  logic [ADDR_W-1:0] word_full;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] result;

  assign ready = (state_q != WAIT);

  // Bounds check uses the full shifted address so high bits never alias.
  always_comb begin
    word_full    = bus.address_mem >> SH;
    idx          = word_full[IDX_W-1:0];
    misaligned   = (bus.address_mem & ADDR_W'((DATA_W / 8) - 1)) != '0;
    out_of_range = word_full >= ADDR_W'(DEPTH);
    legal        = (bus.read_mem != bus.write_mem) && !misaligned && !out_of_range;
    accept       = bus.req_mem && ready;
    we           = accept && legal && bus.write_mem;
    result       = (legal && bus.read_mem && written_q[idx]) ? mem_q[idx] : '0;
  end

  // Result is captured at accept; it reaches data_q only on entry to RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    pend_d  = pend_q;
    case (state_q)
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          data_d  = pend_q;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          if (legal && (LATENCY > 1)) begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
            pend_d  = result;
          end else begin
            state_d = RESP;
            data_d  = result;
            err_d   = !legal;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_q <= '0;
    end else if (we) begin
      written_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= bus.valA_mem;
    end
  end

  assign bus.ready_mem   = ready;
  assign bus.valid_mem   = (state_q == RESP);
  assign bus.data_memory = data_q;
  assign bus.error_mem   = err_q;
endmodule

// File: tb/tb_dmem_pipe.sv
// Bench for dmem_pipe: three instances (LATENCY 2, 1, 5) checked every cycle
// against a transaction-level model of responses, readiness and memory contents.
module tb_dmem_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req [3];
  logic        rd  [3];
  logic        wr  [3];
  logic [63:0] addr[3];
  logic [63:0] wdat[3];
  wire         rdy [3];
  wire         vld [3];
  wire         err [3];
  wire  [63:0] dout[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    dmem_pipe_if #(.DATA_W(64), .ADDR_W(64)) bus ();
    assign bus.req_mem     = req[g];
    assign bus.read_mem    = rd[g];
    assign bus.write_mem   = wr[g];
    assign bus.address_mem = addr[g];
    assign bus.valA_mem    = wdat[g];
    assign rdy[g]  = bus.ready_mem;
    assign vld[g]  = bus.valid_mem;
    assign err[g]  = bus.error_mem;
    assign dout[g] = bus.data_memory;
    dmem_pipe #(.DATA_W(64), .ADDR_W(64), .DEPTH(8192), .LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
    );
  end

  typedef struct {
    int          inst;
    longint      due;
    logic [63:0] data;
    logic        err;
  } resp_t;

  resp_t       expq[$];
  logic [63:0] mdl [longint];
  longint      busy_until[3];
  int          checks = 0;
  int          failures = 0;
  bit          chk_en = 0;

  logic [63:0] last_data[3];
  logic        last_err [3];
  longint      last_cyc [3];
  int          resp_cnt [3];
  int          run      [3];
  int          max_run  [3];

  function automatic int lat_of(int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 5);
  endfunction

  function automatic bit legal_req(bit r, bit w, logic [63:0] a);
    return (r != w) && (a[2:0] == 3'b000) && ((a >> 3) < 64'd8192);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        int k;
        k = -1;
        check($sformatf("ready%0d", i), 64'(rdy[i]),
              (!rst_n || cyc >= busy_until[i]) ? 64'd1 : 64'd0);
        if (!rst_n) begin
          check($sformatf("rst_valid%0d", i), 64'(vld[i]), 64'd0);
          check($sformatf("rst_data%0d", i), dout[i], 64'd0);
          check($sformatf("rst_err%0d", i), 64'(err[i]), 64'd0);
        end else begin
          for (int q = 0; q < expq.size(); q++)
            if (expq[q].inst == i && expq[q].due == cyc) k = q;
          if (k >= 0) begin
            check($sformatf("valid%0d", i), 64'(vld[i]), 64'd1);
            check($sformatf("err%0d", i), 64'(err[i]), 64'(expq[k].err));
            if (!expq[k].err) check($sformatf("data%0d", i), dout[i], expq[k].data);
            expq.delete(k);
          end else begin
            check($sformatf("idle_valid%0d", i), 64'(vld[i]), 64'd0);
          end
        end
        if (vld[i] === 1'b1) begin
          resp_cnt[i]++;
          last_data[i] = dout[i];
          last_err[i]  = err[i];
          last_cyc[i]  = cyc;
          run[i]++;
        end else begin
          run[i] = 0;
        end
        if (run[i] > max_run[i]) max_run[i] = run[i];
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input int i, input bit r, input bit w, input logic [63:0] a,
                       input logic [63:0] d, output longint acc);
    resp_t  e;
    longint key;
    while (cyc < busy_until[i]) begin
      @(posedge clk);
      #1;
    end
    req[i] = 1'b1; rd[i] = r; wr[i] = w; addr[i] = a; wdat[i] = d;
    acc = cyc;
    @(posedge clk);
    key    = longint'(i) * 64'd1048576 + longint'(a >> 3);
    e.inst = i;
    e.err  = !legal_req(r, w, a);
    e.due  = acc + (e.err ? 1 : lat_of(i));
    e.data = '0;
    if (!e.err && w) mdl[key] = d;
    else if (!e.err && mdl.exists(key)) e.data = mdl[key];
    expq.push_back(e);
    busy_until[i] = e.due;
    #1;
    req[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    while (cyc <= busy_until[i]) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    expq.delete();
    mdl.delete();
    for (int i = 0; i < 3; i++) busy_until[i] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  longint a0, a1;
  int     c0;
  bit     ill_r[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  bit     ill_w[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [63:0] ill_a[4] = '{64'h43, 64'h10000, 64'h40, 64'h40};

  initial begin
    for (int i = 0; i < 3; i++) begin
      req[i] = 0; rd[i] = 0; wr[i] = 0; addr[i] = '0; wdat[i] = '0;
      busy_until[i] = 0; resp_cnt[i] = 0; run[i] = 0; max_run[i] = 0;
      last_data[i] = '0; last_err[i] = 0; last_cyc[i] = 0;
    end
    #1;
    rst_n  = 1'b0;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("por_ready%0d", i), 64'(rdy[i]), 64'd1);
      check($sformatf("por_valid%0d", i), 64'(vld[i]), 64'd0);
      check($sformatf("por_data%0d", i), dout[i], 64'd0);
      check($sformatf("por_err%0d", i), 64'(err[i]), 64'd0);
    end

    // Unwritten read returns zero after LATENCY cycles
    issue(0, 1, 0, 64'h40, 64'h0, a0);
    wait_idle(0);
    check("t1_data", last_data[0], 64'h0);
    check("t1_lat", 64'(last_cyc[0] - a0), 64'd2);

    // Write then back-to-back read
    issue(0, 0, 1, 64'h40, 64'hDEADBEEF0BADF00D, a0);
    issue(0, 1, 0, 64'h40, 64'h0, a1);
    wait_idle(0);
    check("t2_spacing", 64'(a1 - a0), 64'd2);
    check("t2_read", last_data[0], 64'hDEADBEEF0BADF00D);

    // Illegal requests answer in cycle 1 with error
    for (int t = 0; t < 4; t++) begin
      issue(0, ill_r[t], ill_w[t], ill_a[t], 64'hFFFF_FFFF_FFFF_FFFF, a0);
      wait_idle(0);
      check($sformatf("t3_err%0d", t), 64'(last_err[0]), 64'd1);
      check($sformatf("t3_lat%0d", t), 64'(last_cyc[0] - a0), 64'd1);
    end
    issue(0, 1, 0, 64'h40, 64'h0, a0);
    wait_idle(0);
    check("t3_keep", last_data[0], 64'hDEADBEEF0BADF00D);

    // Reset during WAIT drops the response and clears written bits
    issue(0, 0, 1, 64'h80, 64'h1234, a0);
    wait_idle(0);
    c0 = resp_cnt[0];
    issue(0, 1, 0, 64'h80, 64'h0, a0);
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    check("t4_dropped", 64'(resp_cnt[0] - c0), 64'd0);
    issue(0, 1, 0, 64'h80, 64'h0, a0);
    wait_idle(0);
    check("t4_read80", last_data[0], 64'h0);
    check("t4_rdcnt", 64'(resp_cnt[0] - c0), 64'd1);
    issue(0, 1, 0, 64'h40, 64'h0, a0);
    wait_idle(0);
    check("t4_read40", last_data[0], 64'h0);

    // LATENCY=1: streaming writes then reads
    c0 = resp_cnt[1];
    max_run[1] = 0;
    for (int k = 0; k < 8; k++)
      issue(1, 0, 1, 64'(k * 8), 64'(k + 1) * 64'h0101010101010101, a0);
    for (int k = 0; k < 8; k++)
      issue(1, 1, 0, 64'(k * 8), 64'h0, a0);
    wait_idle(1);
    check("t5_count", 64'(resp_cnt[1] - c0), 64'd16);
    check("t5_run", 64'(max_run[1]), 64'd16);
    check("t5_last", last_data[1], 64'h0808080808080808);

    // LATENCY=5: inputs during WAIT are ignored
    issue(2, 0, 1, 64'h100, 64'hCAFEF00D, a0);
    wait_idle(2);
    c0 = resp_cnt[2];
    issue(2, 1, 0, 64'h100, 64'h0, a0);
    for (int j = 0; j < 4; j++) begin
      req[2] = 1'b1; rd[2] = 1'b0; wr[2] = 1'b1;
      addr[2] = 64'(j * 8); wdat[2] = '1;
      @(posedge clk);
      #1;
    end
    req[2] = 1'b0; wr[2] = 1'b0;
    wait_idle(2);
    check("t6_count", 64'(resp_cnt[2] - c0), 64'd1);
    check("t6_lat", 64'(last_cyc[2] - a0), 64'd5);
    check("t6_data", last_data[2], 64'hCAFEF00D);
    issue(2, 1, 0, 64'h0, 64'h0, a0);
    wait_idle(2);
    check("t6_ignored", last_data[2], 64'h0);

    repeat (2) @(posedge clk);
    #1;
    check("q_empty", 64'(expq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_pipe.md
# dmem_pipe

Parametrised, clocked data memory for the Y86 memory stage. It replaces the combinational, level-sensitive store with a synchronous request/response port that has:
- configurable word width, depth and read latency
- byte addressing with alignment checks and bounds checks
- read-as-zero for words never written since reset

One request is in flight at a time. The memory stage stalls on `ready_mem` and consumes results on `valid_mem`.

## Interface
- `DATA_W`, 64: word width in bits; multiple of 8, power of two.
- `ADDR_W`, 64: byte-address width.
- `DEPTH`, 8192: number of words; power of two.
- `LATENCY`, 2: cycles from acceptance to response for legal requests; legal range 1..15.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_mem`  in  1  request valid.
- `ready_mem`  out  1  block can accept a request this cycle.
- `address_mem`  in  `ADDR_W`  byte address.
- `valA_mem`  in  `DATA_W`  write data.
- `read_mem`  in  1  read request.
- `write_mem`  in  1  write request.
- `data_memory`  out  `DATA_W`  read data; qualified by `valid_mem`.
- `valid_mem`  out  1  one-cycle response strobe.
- `error_mem`  out  1  response is an error; qualified by `valid_mem`.

## Operation
- Terms:
  - `SH` = log2(`DATA_W`/8).
  - Word index = `address_mem` >> `SH`.
  - Accept = `req_mem` & `ready_mem` sampled at a rising edge.
- The request is illegal if any of the following holds:
  - `read_mem` == `write_mem` (both high or both low);
  - `address_mem`[`SH`-1:0] != 0 (misaligned);
  - word index >= `DEPTH` (out of range; every upper address bit is checked, there is no wrap-around).
- Illegal request:
  - no array access and no bitmap change;
  - error response.
- Legal write:
  - the array word is written at the accept edge;
  - the word's written-bit is set;
  - a response follows with `data_memory` = 0.
- Legal read:
  - the word is sampled at the accept edge;
  - if its written-bit is clear, the result is 0;
  - a write accepted at edge k is visible to a read accepted at any later edge.
- Written-bit bitmap: `DEPTH` bits, cleared by reset. Array contents are not reset.
- FSM states:
  - IDLE: `ready_mem` = 1.
    - Legal accept with `LATENCY` > 1 -> WAIT, counter loaded with `LATENCY`-1.
    - Legal accept with `LATENCY` == 1, or illegal accept -> RESP.
  - WAIT: `ready_mem` = 0; the counter decrements each cycle. Counter == 1 -> RESP.
  - RESP:
    - `valid_mem` = 1 and `ready_mem` = 1;
    - an accept in RESP is handled exactly as in IDLE;
    - with no accept, the FSM returns to IDLE.
- `data_memory` and `error_mem` update only on entry to RESP and hold their value until the next response.
- Inputs are ignored when `req_mem` is low or `ready_mem` is low.

## Timing
- Reset values (asynchronous, on assertion): state IDLE, `ready_mem` = 1, `valid_mem` = 0, `error_mem` = 0, `data_memory` = 0, counter = 0, bitmap cleared.
- Cycle numbering: the accept happens in cycle 0.
  - Legal request: `valid_mem` high in cycle `LATENCY` only; `ready_mem` low in cycles 1..`LATENCY`-1.
  - Illegal request: `valid_mem` high in cycle 1, regardless of `LATENCY`.
- Throughput:
  - back-to-back legal requests: one per `LATENCY` cycles;
  - with `LATENCY` = 1: one per cycle, `ready_mem` constantly 1 and `valid_mem` high every cycle after an accept.
- Reset mid-operation:
  - the in-flight response is dropped and no `valid_mem` is produced;
  - a write already committed stays in the array but reads back as 0, because its written-bit is cleared.
- Simultaneous events: a new accept in the RESP cycle is legal. The new response overwrites `data_memory` and `error_mem` no earlier than its own response cycle.

## Test plan
- Reset, then read byte address 0x40 -> `valid_mem` in cycle 2 (`LATENCY` = 2), `data_memory` = 0, `error_mem` = 0.
- Write 0xDEADBEEF_0BADF00D to address 0x40, then read 0x40 back-to-back -> write response with `data_memory` = 0; read response with `data_memory` = 0xDEADBEEF_0BADF00D; accepts 2 cycles apart; `ready_mem` low for exactly 1 cycle each.
- Misaligned read at 0x43, out-of-range read at 0x10000 (`DEPTH` = 8192, `DATA_W` = 64), and a request with both `read_mem` and `write_mem` high -> each gives `valid_mem` & `error_mem` in cycle 1. A follow-up read of 0x40 still returns the previously written value.
- Write 0x1234 to 0x80, pulse `rst_n` low mid-WAIT of a read, then read 0x80 -> no response for the aborted read; the new read returns 0.
- `LATENCY` = 1 instance: 8 consecutive writes to 0x0..0x38 and then 8 reads -> 16 consecutive `valid_mem` cycles; reads return the written data in order.
- `LATENCY` = 5 instance: `req_mem` held high with changing `address_mem` during WAIT -> inputs ignored; exactly one response, in cycle 5, for the request accepted in cycle 0.
